// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and width helpers for the fully-connected address sequencer
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Width of an address bus that must index v entries; never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int rows_of(input int in_max, input int pack);
    return in_max / pack;
  endfunction

  function automatic int bytes_of(input int dwidth);
    return dwidth / 8;
  endfunction

  // Byte-enable bit bit_idx of a RAM row is set when it falls inside lane 'lane'.
  function automatic logic lane_en(input int unsigned bit_idx, input int unsigned lane,
                                   input int unsigned be);
    return (bit_idx >= lane * be) && (bit_idx < (lane + 1) * be);
  endfunction

endpackage

// File: rtl/fc_wr_mask_gen.sv
// rtl/fc_wr_mask_gen.sv - input-RAM write pointer and rotating byte-enable generator
module fc_wr_mask_gen
  import fc_pkg::*;
#(
  parameter int PACK = 4,
  parameter int BE   = 2,
  parameter int ROWS = 16,
  parameter int DAW  = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 clear,
  input  logic                 wr_fire,
  output logic [PACK*BE-1:0]   we_data,
  output logic [DAW-1:0]       addr_wr
);

  localparam int LW = clog2_min1(PACK);
  localparam logic [DAW-1:0] ROW_LAST  = DAW'(ROWS - 1);
  localparam logic [LW-1:0]  LANE_LAST = LW'(PACK - 1);

  logic [DAW-1:0]     wr_row;
  logic [LW-1:0]      lane;
  logic [PACK*BE-1:0] mask;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PACK * BE; i++) begin
      mask[i] = lane_en(i, 32'(lane), BE);
    end
  end

  // Each full pass over the rows moves the write to the next element lane.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_row  <= '0;
      lane    <= '0;
      we_data <= '0;
      addr_wr <= '0;
    end else if (clear) begin
      wr_row  <= '0;
      lane    <= '0;
      we_data <= '0;
    end else if (wr_fire) begin
      we_data <= mask;
      addr_wr <= wr_row;
      if (wr_row == ROW_LAST) begin
        wr_row <= '0;
        lane   <= (lane == LANE_LAST) ? '0 : lane + 1'b1;
      end else begin
        wr_row <= wr_row + 1'b1;
      end
    end else begin
      we_data <= '0;
    end
  end

endmodule

// File: rtl/fc_addr_sequencer.sv
// rtl/fc_addr_sequencer.sv - FC layer sequencer: input-RAM load, then multi-port data/weight/bias reads
module fc_addr_sequencer
  import fc_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int PACK    = 4,
  parameter int PORTS   = 2,
  parameter int IN_MAX  = 64,
  parameter int OUT_MAX = 10,
  localparam int ROWS   = rows_of(IN_MAX, PACK),
  localparam int BE     = bytes_of(DWIDTH),
  localparam int DAW    = clog2_min1(ROWS),
  localparam int WAW    = clog2_min1(ROWS * OUT_MAX),
  localparam int BAW    = clog2_min1(OUT_MAX)
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 wr_en,
  output logic                 wr_ready,
  output logic [PACK*BE-1:0]   we_data,
  output logic [DAW-1:0]       addr_wr,
  input  logic                 start,
  input  logic [DAW:0]         cfg_rows,
  input  logic [BAW:0]         cfg_outs,
  input  logic                 acc_ready,
  output logic                 re_data,
  output logic                 re_weight,
  output logic                 re_bias,
  output logic [PORTS*DAW-1:0] addr_data,
  output logic [PORTS*WAW-1:0] addr_weight,
  output logic [BAW-1:0]       addr_bias,
  output logic                 rd_valid,
  output logic [PORTS-1:0]     rd_lane_vld,
  output logic                 rd_first,
  output logic                 rd_last,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  localparam logic [DAW:0] ROWS_W = (DAW+1)'(ROWS);
  localparam logic [BAW:0] OUTS_W = (BAW+1)'(OUT_MAX);

  state_t         state, state_nx;
  logic [DAW:0]   row;
  logic [BAW-1:0] neuron;
  logic [WAW-1:0] wbase;
  logic [DAW:0]   cfg_rows_q;
  logic [BAW:0]   cfg_outs_q;
  logic [DAW+1:0] row_end;
  logic           run, idle, cfg_ok, wr_fire, start_fire, run_go;
  logic           consume, last_beat, last_neuron;

  assign run         = (state == ST_RUN);
  assign idle        = (state == ST_IDLE);
  assign cfg_ok      = (cfg_rows != '0) && (cfg_rows <= ROWS_W) &&
                       (cfg_outs != '0) && (cfg_outs <= OUTS_W);
  assign wr_fire     = idle && wr_en;
  assign start_fire  = idle && !wr_en && start;
  assign run_go      = start_fire && cfg_ok;
  assign consume     = run && acc_ready;
  assign row_end     = {1'b0, row} + (DAW+2)'(PORTS);
  assign last_beat   = row_end >= {1'b0, cfg_rows_q};
  assign last_neuron = {1'b0, neuron} == (cfg_outs_q - 1'b1);

  fc_wr_mask_gen #(
    .PACK (PACK),
    .BE   (BE),
    .ROWS (ROWS),
    .DAW  (DAW)
  ) u_wr_mask_gen (
    .clk     (clk),
    .nreset  (nreset),
    .clear   (run_go),
    .wr_fire (wr_fire),
    .we_data (we_data),
    .addr_wr (addr_wr)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    cfg_err   = 1'b0;
    re_data   = 1'b0;
    re_weight = 1'b0;
    re_bias   = 1'b0;
    rd_valid  = 1'b0;
    rd_first  = 1'b0;
    rd_last   = 1'b0;
    case (state)
      ST_IDLE: begin
        wr_ready = 1'b1;
        busy     = 1'b0;
        if (start_fire) begin
          state_nx = cfg_ok ? ST_RUN : ST_ERR;
        end
      end
      ST_RUN: begin
        re_data   = 1'b1;
        re_weight = 1'b1;
        rd_valid  = 1'b1;
        rd_first  = (row == '0);
        re_bias   = (row == '0);
        rd_last   = last_beat;
        if (consume && last_beat && last_neuron) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_ERR: begin
        done     = 1'b1;
        cfg_err  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Weight base steps by cfg_rows per neuron, so n*cfg_rows never needs a multiplier.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      row        <= '0;
      neuron     <= '0;
      wbase      <= '0;
      cfg_rows_q <= '0;
      cfg_outs_q <= '0;
    end else if (run_go) begin
      row        <= '0;
      neuron     <= '0;
      wbase      <= '0;
      cfg_rows_q <= cfg_rows;
      cfg_outs_q <= cfg_outs;
    end else if (consume) begin
      if (!last_beat) begin
        row <= row + (DAW+1)'(PORTS);
      end else if (!last_neuron) begin
        row    <= '0;
        neuron <= neuron + 1'b1;
        wbase  <= wbase + WAW'(cfg_rows_q);
      end else begin
        row    <= '0;
        neuron <= '0;
        wbase  <= '0;
      end
    end
  end

  assign addr_bias = run ? neuron : '0;

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [DAW:0]   r_p;
    logic [WAW-1:0] w_p;
    logic           vld;

    // r+p keeps the extra bit so row ROWS does not alias back to row 0.
    assign r_p = row + (DAW+1)'(p);
    assign vld = run && (r_p < cfg_rows_q);
    assign w_p = wbase + WAW'(r_p);

    assign rd_lane_vld[p]             = vld;
    assign addr_data[p*DAW +: DAW]    = vld ? r_p[DAW-1:0] : '0;
    assign addr_weight[p*WAW +: WAW]  = vld ? w_p : '0;
  end

endmodule

// File: tb/tb_fc_addr_sequencer.sv
// tb/tb_fc_addr_sequencer.sv - randomized self-checking bench for fc_addr_sequencer
module tb_fc_addr_sequencer;

  localparam int ROWS    = 16;
  localparam int OUT_MAX = 10;
  localparam int PORTS   = 2;

  logic        clk;
  logic        nreset;
  logic        wr_en;
  logic        wr_ready;
  logic [7:0]  we_data;
  logic [3:0]  addr_wr;
  logic        start;
  logic [4:0]  cfg_rows;
  logic [4:0]  cfg_outs;
  logic        acc_ready;
  logic        re_data;
  logic        re_weight;
  logic        re_bias;
  logic [7:0]  addr_data;
  logic [15:0] addr_weight;
  logic [3:0]  addr_bias;
  logic        rd_valid;
  logic [1:0]  rd_lane_vld;
  logic        rd_first;
  logic        rd_last;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int tests;
  int fails;

  // Reference pointers of the input-RAM writer.
  int m_row;
  int m_lane;

  logic [47:0] obs;
  assign obs = {busy, wr_ready, done, cfg_err, rd_valid, re_data, re_weight, re_bias,
                rd_first, rd_last, rd_lane_vld, addr_bias, addr_data, addr_weight, we_data};

  fc_addr_sequencer dut (
    .clk         (clk),
    .nreset      (nreset),
    .wr_en       (wr_en),
    .wr_ready    (wr_ready),
    .we_data     (we_data),
    .addr_wr     (addr_wr),
    .start       (start),
    .cfg_rows    (cfg_rows),
    .cfg_outs    (cfg_outs),
    .acc_ready   (acc_ready),
    .re_data     (re_data),
    .re_weight   (re_weight),
    .re_bias     (re_bias),
    .addr_data   (addr_data),
    .addr_weight (addr_weight),
    .addr_bias   (addr_bias),
    .rd_valid    (rd_valid),
    .rd_lane_vld (rd_lane_vld),
    .rd_first    (rd_first),
    .rd_last     (rd_last),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mask_of(input int lane);
    logic [7:0] m;
    m = 8'h03;
    return m << (2 * lane);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    wr_en = 1'b0; start = 1'b0; acc_ready = 1'b0;
    cfg_rows = '0; cfg_outs = '0;
    tick();
    tick();
    tests++;
    if (obs !== {1'b0, 1'b1, 46'd0}) begin
      fails++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, {1'b0, 1'b1, 46'd0});
    end
    nreset = 1'b1;
    m_row = 0;
    m_lane = 0;
    tick();
    tests++;
    if (addr_wr !== 4'd0 || we_data !== 8'd0) begin
      fails++;
      $display("FAIL reset_wr_regs got=%h/%h exp=0/0", addr_wr, we_data);
    end
  endtask

  task automatic test_write_load();
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1;
      tick();
      tests++;
      if (we_data !== mask_of(m_lane) || addr_wr !== 4'(m_row)) begin
        fails++;
        $display("FAIL load_beat%0d got we=%h row=%0d exp we=%h row=%0d",
                 i, we_data, addr_wr, mask_of(m_lane), m_row);
      end
      if (m_row == ROWS - 1) begin
        m_row = 0;
        m_lane = (m_lane + 1) % 4;
      end else begin
        m_row++;
      end
    end
    wr_en = 1'b0;
    tick();
    tests++;
    if (we_data !== 8'd0 || wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_drop got we=%h rdy=%b exp we=00 rdy=1", we_data, wr_ready);
    end
  endtask

  // Random write bursts; start is raised only together with wr_en, where it must be dropped.
  task automatic test_write_random();
    logic [7:0] exp_we;
    logic [3:0] exp_row;
    exp_row = addr_wr;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'($urandom_range(1));
      start = wr_en & 1'($urandom_range(1));
      cfg_rows = 5'd4;
      cfg_outs = 5'd1;
      if (wr_en) begin
        exp_we = mask_of(m_lane);
        exp_row = 4'(m_row);
        if (m_row == ROWS - 1) begin
          m_row = 0;
          m_lane = (m_lane + 1) % 4;
        end else begin
          m_row++;
        end
      end else begin
        exp_we = 8'd0;
      end
      tick();
      tests++;
      if (we_data !== exp_we || addr_wr !== exp_row || busy !== 1'b0) begin
        fails++;
        $display("FAIL wr_random%0d got we=%h row=%0d busy=%b exp we=%h row=%0d busy=0",
                 i, we_data, addr_wr, busy, exp_we, exp_row);
      end
    end
    wr_en = 1'b0;
    start = 1'b0;
    tick();
  endtask

  task automatic test_run(input int rows, input int outs, input int stall_pct);
    logic [47:0] exp;
    logic [3:0]  ad[2];
    logic [7:0]  aw[2];
    logic [1:0]  vld;
    logic        first, last, acc;
    int          stalls, a, beats;
    cfg_rows = 5'(rows);
    cfg_outs = 5'(outs);
    start = 1'b1;
    wr_en = 1'b0;
    acc_ready = 1'b0;
    tick();
    start = 1'b0;
    m_row = 0;
    m_lane = 0;
    stalls = 0;
    beats = 0;
    for (int n = 0; n < outs; n++) begin
      for (int r = 0; r < rows; r += PORTS) begin
        acc = 1'b0;
        while (!acc) begin
          for (int p = 0; p < PORTS; p++) begin
            a = r + p;
            vld[p] = a < rows;
            ad[p] = vld[p] ? 4'(a) : 4'd0;
            aw[p] = vld[p] ? 8'(n * rows + a) : 8'd0;
          end
          first = (r == 0);
          last = (r + PORTS >= rows);
          exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, first, first, last, vld,
                 4'(n), ad[1], ad[0], aw[1], aw[0], 8'h00};
          tests++;
          if (obs !== exp) begin
            fails++;
            $display("FAIL run_beat cfg=%0dx%0d n=%0d r=%0d got=%h exp=%h",
                     rows, outs, n, r, obs, exp);
          end
          acc = (stalls >= 6) || ($urandom_range(99) >= stall_pct);
          acc_ready = acc;
          wr_en = 1'($urandom_range(1));
          start = 1'($urandom_range(1));
          if (n == outs - 1 && last && acc) begin
            wr_en = 1'b0;
            start = 1'b0;
          end
          tick();
          if (acc) stalls = 0;
          else stalls++;
        end
        beats++;
      end
    end
    acc_ready = 1'b0;
    wr_en = 1'b0;
    start = 1'b0;
    tests++;
    if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 44'd0}) begin
      fails++;
      $display("FAIL run_done cfg=%0dx%0d beats=%0d got=%h exp=%h",
               rows, outs, beats, obs, {1'b1, 1'b0, 1'b1, 1'b0, 44'd0});
    end
    tick();
    tests++;
    if (obs !== {1'b0, 1'b1, 46'd0}) begin
      fails++;
      $display("FAIL run_idle cfg=%0dx%0d got=%h exp=%h", rows, outs, obs, {1'b0, 1'b1, 46'd0});
    end
  endtask

  task automatic test_cfg_err(input int rows, input int outs);
    cfg_rows = 5'(rows);
    cfg_outs = 5'(outs);
    start = 1'b1;
    tests++;
    if (re_data !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL err_pre cfg=%0dx%0d got re=%b vld=%b done=%b exp 0", rows, outs,
               re_data, rd_valid, done);
    end
    tick();
    start = 1'b0;
    tests++;
    if (obs !== {1'b1, 1'b0, 1'b1, 1'b1, 44'd0}) begin
      fails++;
      $display("FAIL err_pulse cfg=%0dx%0d got=%h exp=%h", rows, outs, obs,
               {1'b1, 1'b0, 1'b1, 1'b1, 44'd0});
    end
    tick();
    tests++;
    if (obs !== {1'b0, 1'b1, 46'd0}) begin
      fails++;
      $display("FAIL err_idle cfg=%0dx%0d got=%h exp=%h", rows, outs, obs, {1'b0, 1'b1, 46'd0});
    end
  endtask

  task automatic test_reset_midrun();
    cfg_rows = 5'd16;
    cfg_outs = 5'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    acc_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (busy !== 1'b1 || addr_bias !== 4'd0 || addr_data !== {4'd11, 4'd10}) begin
      fails++;
      $display("FAIL midrun_pos got busy=%b bias=%0d data=%h exp busy=1 bias=0 data=ba",
               busy, addr_bias, addr_data);
    end
    #2;
    nreset = 1'b0;
    #1;
    tests++;
    if (obs !== {1'b0, 1'b1, 46'd0} || addr_wr !== 4'd0) begin
      fails++;
      $display("FAIL midrun_reset got=%h wr=%0d exp=%h wr=0", obs, addr_wr, {1'b0, 1'b1, 46'd0});
    end
    nreset = 1'b1;
    acc_ready = 1'b0;
    wr_en = 1'b1;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    tests++;
    if (we_data !== 8'h03 || addr_wr !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL midrun_wr_wins got we=%h row=%0d busy=%b done=%b exp we=03 row=0 busy=0 done=0",
               we_data, addr_wr, busy, done);
    end
    tick();
    tests++;
    if (obs !== {1'b0, 1'b1, 46'd0}) begin
      fails++;
      $display("FAIL midrun_after got=%h exp=%h", obs, {1'b0, 1'b1, 46'd0});
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_write_load();
    test_write_random();
    test_run(16, 10, 0);
    test_run(5, 2, 0);
    test_run(16, 10, 40);
    for (int i = 0; i < 4; i++) begin
      test_run($urandom_range(1, ROWS), $urandom_range(1, OUT_MAX), 30);
    end
    test_run(1, 1, 20);
    test_write_random();
    test_cfg_err(16, 0);
    test_cfg_err(17, 10);
    test_cfg_err(0, 3);
    test_cfg_err(8, 11);
    test_cfg_err($urandom_range(17, 31), $urandom_range(1, OUT_MAX));
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
